// File: rtl/seq_gen_disp.sv
// Memory-game sequence generator and timed player: builds a pseudo-random symbol sequence and plays it.
// Optional feature macro: SEQ_NO_REPEAT_EN (adjacent generated symbols are forced to differ).
module seq_gen_disp #(
    parameter int unsigned        MAX_LEN     = 5,
    parameter int unsigned        DIGIT_W     = 4,
    parameter int unsigned        NUM_SYMBOLS = 10,
    parameter int unsigned        LVL_W       = 3,
    parameter int unsigned        ON_CYCLES   = 50_000_000,
    parameter int unsigned        GAP_CYCLES  = 12_500_000,
    parameter int unsigned        LFSR_W      = 16,
    parameter logic [LFSR_W-1:0]  SEED        = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LVL_W-1:0]             cur_lvl,
    input  logic                         b_seq,
    input  logic                         b_show,
    output logic [MAX_LEN*DIGIT_W-1:0]   seq,
    output logic [DIGIT_W-1:0]           seq_digit,
    output logic                         show_seq,
    output logic                         display_done,
    output logic                         new_seq
);

    // Galois (right-shift) feedback masks for maximal-length sequences
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    localparam int unsigned           IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned           MAX_PH   = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned           CNT_W    = $clog2(MAX_PH + 1);
    localparam logic [CNT_W-1:0]      ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(MAX_LEN - 1);
    localparam logic [DIGIT_W-1:0]    NSYM     = DIGIT_W'(NUM_SYMBOLS);
    localparam logic [LFSR_W-1:0]     TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
`ifdef SEQ_NO_REPEAT_EN
    localparam logic [DIGIT_W-1:0]    SYM_LAST = DIGIT_W'(NUM_SYMBOLS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               last_q, last_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [LFSR_W-1:0]              lfsr_q, lfsr_d;
    logic [MAX_LEN*DIGIT_W-1:0]     seq_d;
    logic                           valid_q, valid_d;
    logic                           b_seq_q, b_show_q;
    logic                           seq_press, show_press;
    logic [DIGIT_W-1:0]             cand;
    logic [DIGIT_W-1:0]             seq_digit_d;
    logic                           show_seq_d, display_done_d, new_seq_d;
`ifdef SEQ_NO_REPEAT_EN
    logic [IDX_W-1:0]               prev_idx;
    logic [DIGIT_W-1:0]             prev_sym;
`endif

    // Requested level clamped to 1..MAX_LEN, stored as index of the last symbol to play
    function automatic logic [IDX_W-1:0] clamp_last(input logic [LVL_W-1:0] lvl);
        if (lvl == '0) begin
            return '0;
        end
        if (32'(lvl) > MAX_LEN) begin
            return IDX_LAST;
        end
        return IDX_W'(lvl - LVL_W'(1));
    endfunction

    assign seq_press  = b_seq  & ~b_seq_q;
    assign show_press = b_show & ~b_show_q;

    // Candidate symbol folded into 0..NUM_SYMBOLS-1 from the LFSR low bits
    always_comb begin
        cand = lfsr_q[DIGIT_W-1:0];
        if (cand >= NSYM) begin
            cand = cand - NSYM;
        end
`ifdef SEQ_NO_REPEAT_EN
        prev_idx = idx_q - IDX_W'(1);
        prev_sym = seq[prev_idx*DIGIT_W +: DIGIT_W];
        if ((idx_q != '0) && (cand == prev_sym)) begin
            cand = (cand == SYM_LAST) ? '0 : cand + DIGIT_W'(1);
        end
`endif
    end

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        seq_d          = seq;
        valid_d        = valid_q;

        case (state_q)
            S_IDLE: begin
                if (seq_press) begin
                    state_d = S_GEN;
                    idx_d   = '0;
                    last_d  = clamp_last(cur_lvl);
                end else if (show_press && valid_q) begin
                    state_d = S_ON;
                    idx_d   = '0;
                    cnt_d   = '0;
                    last_d  = clamp_last(cur_lvl);
                end
            end
            S_GEN: begin
                seq_d[idx_q*DIGIT_W +: DIGIT_W] = cand;
                if (idx_q == IDX_LAST) begin
                    valid_d = 1'b1;
                    state_d = S_ON;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = (idx_q == last_q) ? S_DONE : S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        show_seq_d     = (state_d == S_ON);
        seq_digit_d    = show_seq_d ? seq_d[idx_d*DIGIT_W +: DIGIT_W] : '1;
        display_done_d = (state_d == S_DONE);
        new_seq_d      = (state_q == S_GEN) && (state_d == S_ON);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            seq          <= '0;
            valid_q      <= 1'b0;
            b_seq_q      <= 1'b0;
            b_show_q     <= 1'b0;
            seq_digit    <= '1;
            show_seq     <= 1'b0;
            display_done <= 1'b0;
            new_seq      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            seq          <= seq_d;
            valid_q      <= valid_d;
            b_seq_q      <= b_seq;
            b_show_q     <= b_show;
            seq_digit    <= seq_digit_d;
            show_seq     <= show_seq_d;
            display_done <= display_done_d;
            new_seq      <= new_seq_d;
        end
    end

endmodule

// File: tb/tb_seq_gen_disp.sv
// Scoreboard bench for seq_gen_disp: random generate/replay requests against a cycle-trace reference model.
module tb_seq_gen_disp;

    localparam int          ON    = 3;
    localparam int          GAP   = 2;
    localparam int          MAXL  = 5;
    localparam int          NS    = 10;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] TAPS  = 16'hD008;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  cur_lvl = 3'd0;
    logic        b_seq = 1'b0;
    logic        b_show = 1'b0;
    logic [19:0] seq;
    logic [3:0]  seq_digit;
    logic        show_seq;
    logic        display_done;
    logic        new_seq;

    always #5 clk = ~clk;

    seq_gen_disp #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cur_lvl      (cur_lvl),
        .b_seq        (b_seq),
        .b_show       (b_show),
        .seq          (seq),
        .seq_digit    (seq_digit),
        .show_seq     (show_seq),
        .display_done (display_done),
        .new_seq      (new_seq)
    );

    typedef struct {
        bit          gen;
        int          e;
        int          len;
        logic [19:0] sq;
    } txn_t;

    txn_t        exq[$];
    int          checks = 0;
    int          errors = 0;

    // Reference LFSR and per-edge history of the value seen by each clock edge
    int          ecnt = 0;
    bit          rst_q = 1'b0;
    logic [15:0] m_lfsr = SEED;
    logic [15:0] hist [0:32767];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    always @(posedge clk) begin
        hist[ecnt[14:0]] <= m_lfsr;
        ecnt             <= ecnt + 1;
        rst_q            <= rst;
        m_lfsr           <= !rst ? SEED : lfsr_step(m_lfsr);
    end

    // Sequence produced by a generate request whose press was sampled at edge e
    function automatic logic [19:0] gen_seq(input int e);
        logic [19:0] r;
        logic [3:0]  c;
        logic [3:0]  prev;
        int          n;
        r    = '0;
        prev = '0;
        for (int k = 0; k < MAXL; k++) begin
            n = e + 1 + k;
            c = hist[n[14:0]][3:0];
            if (c >= 4'(NS)) c = c - 4'(NS);
`ifdef SEQ_NO_REPEAT_EN
            if (k > 0 && c == prev) c = (c == 4'(NS - 1)) ? 4'd0 : c + 4'd1;
`endif
            r[k*4 +: 4] = c;
            prev = c;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Monitor: expected per-cycle trace of one episode
    bit          t_show[$];
    logic [3:0]  t_dig[$];
    bit          t_new[$];
    bit          t_done[$];
    bit          ep_active = 1'b0;
    int          pos = 0;
    logic [19:0] ep_seq;

    task automatic build_trace(input txn_t t);
        t_show.delete(); t_dig.delete(); t_new.delete(); t_done.delete();
        for (int i = 0; i < t.len; i++) begin
            for (int c = 0; c < ON; c++) begin
                t_show.push_back(1'b1);
                t_dig.push_back(t.sq[i*4 +: 4]);
                t_new.push_back(t.gen && i == 0 && c == 0);
                t_done.push_back(1'b0);
            end
            if (i < t.len - 1) begin
                for (int c = 0; c < GAP; c++) begin
                    t_show.push_back(1'b0); t_dig.push_back(4'hF);
                    t_new.push_back(1'b0);  t_done.push_back(1'b0);
                end
            end
        end
        t_show.push_back(1'b0); t_dig.push_back(4'hF);
        t_new.push_back(1'b0);  t_done.push_back(1'b1);
    endtask

    task automatic cmp_cycle();
        logic [3:0] s;
        chk("show_seq", 32'(show_seq), 32'(t_show[pos]));
        chk("seq_digit", 32'(seq_digit), 32'(t_dig[pos]));
        chk("new_seq", 32'(new_seq), 32'(t_new[pos]));
        chk("display_done", 32'(display_done), 32'(t_done[pos]));
        pos++;
        if (pos == t_show.size()) begin
            ep_active = 1'b0;
            chk("seq_value", 32'(seq), 32'(ep_seq));
            for (int k = 0; k < MAXL; k++) begin
                s = seq[k*4 +: 4];
                chk("sym_range", 32'(s < 4'(NS)), 32'd1);
`ifdef SEQ_NO_REPEAT_EN
                if (k > 0) chk("adjacent_differ", 32'(s != seq[(k-1)*4 +: 4]), 32'd1);
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        txn_t cur;
        if (!rst_q) begin
            exq.delete();
            ep_active = 1'b0;
            chk("rst_seq", 32'(seq), 32'd0);
            chk("rst_seq_digit", 32'(seq_digit), 32'hF);
            chk("rst_show_seq", 32'(show_seq), 32'd0);
            chk("rst_display_done", 32'(display_done), 32'd0);
            chk("rst_new_seq", 32'(new_seq), 32'd0);
        end else if (!ep_active) begin
            if (show_seq || new_seq || display_done) begin
                if (exq.size() == 0) begin
                    chk("spurious_activity", 32'({show_seq, new_seq, display_done}), 32'd0);
                end else begin
                    cur = exq.pop_front();
                    if (cur.gen) cur.sq = gen_seq(cur.e);
                    ep_seq = cur.sq;
                    build_trace(cur);
                    chk("start_edge", 32'(ecnt), 32'(cur.gen ? cur.e + MAXL + 1 : cur.e + 1));
                    ep_active = 1'b1;
                    pos = 0;
                    cmp_cycle();
                end
            end
        end else begin
            cmp_cycle();
        end
    end

    // Stimulus side
    bit          m_valid = 1'b0;
    logic [19:0] m_seq = '0;

    function automatic int clamp_len(input int lvl);
        if (lvl == 0) return 1;
        if (lvl > MAXL) return MAXL;
        return lvl;
    endfunction

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((exq.size() != 0 || ep_active) && n < 400);
        if (exq.size() != 0 || ep_active) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: playback still pending after %0d cycles, required completion", n);
            exq.delete();
            ep_active = 1'b0;
        end
    endtask

    task automatic press(input bit ds, input bit dsh, input int lvl, input int hold, input bit noise);
        txn_t t;
        int   e;
        wait_idle();
        #1;
        e       = ecnt;
        cur_lvl = 3'(lvl);
        b_seq   = ds;
        b_show  = dsh;
        if (ds || (dsh && m_valid)) begin
            t.gen = ds;
            t.e   = e;
            t.len = clamp_len(lvl);
            t.sq  = m_seq;
            exq.push_back(t);
        end
        repeat (hold) @(posedge clk);
        #1;
        b_seq  = 1'b0;
        b_show = 1'b0;
        if (noise && hold == 1) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 0) b_seq = 1'b1; else b_show = 1'b1;
            @(posedge clk); #1;
            b_seq  = 1'b0;
            b_show = 1'b0;
        end
        if (ds) begin
            while (ecnt <= e + MAXL) begin
                @(posedge clk); #1;
            end
            m_seq   = gen_seq(e);
            m_valid = 1'b1;
        end
    endtask

    task automatic reset_mid_play();
        txn_t t;
        wait_idle();
        #1;
        t.gen = 1'b0; t.e = ecnt; t.len = MAXL; t.sq = m_seq;
        exq.push_back(t);
        cur_lvl = 3'd5;
        b_show  = 1'b1;
        @(posedge clk); #1;
        b_show = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        m_valid = 1'b0;
        m_seq   = '0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        press(0, 1, 3, 1, 0);
        repeat (8) @(posedge clk);
        press(1, 0, 3, 1, 0);
        press(0, 1, 5, 1, 0);
        press(0, 1, 0, 1, 0);
        press(0, 1, 7, 1, 1);
        press(1, 1, 2, 2, 0);
        press(1, 0, 4, 1, 1);

        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       press(1, 0, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
                2:       press(1, 1, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
                default: press(0, 1, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            endcase
        end

        reset_mid_play();
        press(0, 1, 4, 1, 0);
        repeat (10) @(posedge clk);
        press(1, 0, 5, 1, 0);
        press(0, 1, 1, 3, 0);

`ifdef SEQ_NO_REPEAT_EN
        for (int g = 0; g < 1000; g++) press(1, 0, 1, 1, 0);
`endif

        wait_idle();
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
